rom_fetch_arbiter: RTL and testbench
====================================

ROM_FETCH_ARBITER -- requirements
Module: rom_fetch_arbiter

Interface
REQ-001 Parameter ROM_ADDR_BITS, default 4, ROM address width.
REQ-002 Parameter ROM_WIDTH, default 8, byte width; ROM word is 2*ROM_WIDTH.
REQ-003 Parameter BEGIN_ADDR, default 0, lowest legal fetch address.
REQ-004 Parameter END_ADDR, default 15, highest populated ROM byte address.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 Req0 / Req1  in  1  fetch request, port 0 / port 1.
REQ-008 Addr0 / Addr1  in  ROM_ADDR_BITS  fetch byte address, stable while Req high.
REQ-009 Ack0 / Ack1  out  1  one-cycle completion pulse, per port.
REQ-010 Err0 / Err1  out  1  address-range error, valid with Ack.
REQ-011 Data0 / Data1  out  2*ROM_WIDTH  fetched word {byte[a+1], byte[a]}, valid with Ack.
REQ-012 ROMEnable  out  1  ROM enable.
REQ-013 RomAddress  out  ROM_ADDR_BITS  ROM address.
REQ-014 RomData  in  2*ROM_WIDTH  ROM registered output (1-cycle latency after enabled edge).
REQ-015 Busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states: IDLE, ISSUE, CAPTURE, DONE; one transaction in flight at a time.
REQ-017 IDLE: if no Req, stay; else select winner, register its address into RomAddress, latch winner id.
REQ-018 Legal address: BEGIN_ADDR <= a <= END_ADDR-1 (a+1 must be populated, no wrap).
REQ-019 IDLE with legal winner -> ISSUE, ROMEnable set to 1 on the same edge.
REQ-020 IDLE with illegal winner -> DONE directly, no ROM access, Err and Ack for winner, Data 0.
REQ-021 ISSUE -> CAPTURE; ROMEnable cleared to 0 on this edge (high exactly one cycle).
REQ-022 CAPTURE: register RomData into winner's Data, set winner's Ack, -> DONE.
REQ-023 DONE: winner's Ack (and Err if set) high this cycle only; Req inputs ignored; -> IDLE.
REQ-024 Latency: Req sampled in IDLE at edge 0 -> Ack high cycle 3 (legal) or cycle 1 (illegal).
REQ-025 Arbitration round-robin: single request wins; both requesting -> port not granted last.
REQ-026 Last-grant pointer updates only on a grant; illegal-address grants count.
REQ-027 Non-winner Ack/Err/Data stay 0; Data of winner holds value only during Ack cycle, else 0.
REQ-028 Requester drops Req or changes Addr in Ack cycle; a Req still high in the cycle after DONE is a new request.
REQ-029 Req deasserted mid-transaction does not abort; transaction completes and Acks.

Reset
REQ-030 RST asserted: state IDLE, ROMEnable 0, RomAddress 0, Ack0/1 0, Err0/1 0, Data0/1 0, Busy 0, immediately.
REQ-031 Last-grant pointer resets to port 1, so port 0 wins first tie.
REQ-032 Reset mid-transaction discards it; no Ack issued for it after release.

Structure
REQ-033 Package rom_arb_pkg holds state encoding constants and port-count constant (2).
REQ-034 Sub-module rom_arb_rr_pick: combinational 2-way round-robin select from Req vector and pointer.
REQ-035 FSM, range check, output registers reside in rom_fetch_arbiter.

Verification
REQ-036 Req0=1, Addr0=4, ROM[4]=0x11, ROM[5]=0x22 -> ROMEnable high cycle 1 only, Ack0 cycle 3, Data0=0x2211, Err0=0.
REQ-037 Req0 and Req1 both held from reset release, Addr0=2, Addr1=6 -> grants 0,1,0,1 alternating, one Ack per 4 cycles.
REQ-038 Req1=1, Addr1=15 (END_ADDR) -> ROMEnable never high, Ack1=Err1=1 cycle 1, Data1=0.
REQ-039 RST pulsed during CAPTURE of port 0 fetch -> all outputs 0 at once, no Ack0 after release, next tie grants port 0.
REQ-040 Req0 pulsed one cycle in IDLE then dropped -> transaction completes, Ack0 in cycle 3, Busy high cycles 1-3.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: FSM state encoding, requester port count and fetch address range helper
package rom_arb_pkg;
  localparam int N_PORTS = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  function automatic logic addr_legal(int a, int lo, int hi);
    return a >= lo && a < hi;
  endfunction
endpackage

// File: rtl/rom_arb_rr_pick.sv
// rom_arb_rr_pick: 2-way round-robin select; req vector and last grant in, any request and winning port out
module rom_arb_rr_pick
  import rom_arb_pkg::*;
(
  input  logic [N_PORTS-1:0] req,
  input  logic               last,
  output logic               any,
  output logic               win
);
  assign any = |req;
  assign win = &req ? ~last : req[1];
endmodule

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: two-port ROM word fetch arbiter; CLK/RST, Req/Addr in, Ack/Err/Data out per port, ROMEnable/RomAddress/RomData ROM side, Busy
module rom_fetch_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ROM_ADDR_BITS = 4,
  parameter int ROM_WIDTH     = 8,
  parameter int BEGIN_ADDR    = 0,
  parameter int END_ADDR      = 15
)(
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Req0,
  input  logic                     Req1,
  input  logic [ROM_ADDR_BITS-1:0] Addr0,
  input  logic [ROM_ADDR_BITS-1:0] Addr1,
  output logic                     Ack0,
  output logic                     Ack1,
  output logic                     Err0,
  output logic                     Err1,
  output logic [2*ROM_WIDTH-1:0]   Data0,
  output logic [2*ROM_WIDTH-1:0]   Data1,
  output logic                     ROMEnable,
  output logic [ROM_ADDR_BITS-1:0] RomAddress,
  input  logic [2*ROM_WIDTH-1:0]   RomData,
  output logic                     Busy
);
  state_t state, nxt;
  logic gnt, any, win, legal, sel, fin, fail;
  logic [ROM_ADDR_BITS-1:0] win_addr;
  rom_arb_rr_pick u_pick (.req({Req1, Req0}), .last(gnt), .any(any), .win(win));
  assign win_addr = win ? Addr1 : Addr0;
  assign legal = addr_legal(int'(win_addr), BEGIN_ADDR, END_ADDR);
  assign Busy = state != IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (any ? (legal ? ISSUE : DONE) : IDLE) :
          state == ISSUE ? CAPTURE : state == CAPTURE ? DONE : IDLE;
  always_comb begin
    fail = state == IDLE && any && !legal;
    fin = fail || state == CAPTURE;
    sel = state == IDLE ? win : gnt;
  end
  // gnt doubles as the round-robin pointer and the in-flight winner id
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      gnt <= 1'b1;
      ROMEnable <= 1'b0;
      RomAddress <= '0;
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      Err0 <= 1'b0;
      Err1 <= 1'b0;
      Data0 <= '0;
      Data1 <= '0;
    end else begin
      ROMEnable <= nxt == ISSUE;
      if (state == IDLE && any) begin
        gnt <= win;
        RomAddress <= win_addr;
      end
      Ack0 <= fin && !sel;
      Ack1 <= fin && sel;
      Err0 <= fail && !sel;
      Err1 <= fail && sel;
      Data0 <= state == CAPTURE && !gnt ? RomData : '0;
      Data1 <= state == CAPTURE && gnt ? RomData : '0;
    end
endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb_rom_fetch_arbiter: randomized and directed bench with a transaction-level reference model and ROM
module tb_rom_fetch_arbiter;
  logic CLK = 0, RST = 0;
  logic Req0 = 0, Req1 = 0;
  logic [3:0] Addr0 = 0, Addr1 = 0;
  logic Ack0, Ack1, Err0, Err1, ROMEnable, Busy;
  logic [15:0] Data0, Data1, RomData;
  logic [3:0] RomAddress;
  logic [7:0] rom [0:15];
  int checks = 0, failures = 0;
  int ph = 0, len = 0, w = 0, last = 1, wa = 0;
  logic ok = 0;
  logic [15:0] exp_data = 0;
  rom_fetch_arbiter #(.ROM_ADDR_BITS(4), .ROM_WIDTH(8), .BEGIN_ADDR(0), .END_ADDR(15)) dut (
    .CLK(CLK), .RST(RST), .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1), .Data0(Data0), .Data1(Data1),
    .ROMEnable(ROMEnable), .RomAddress(RomAddress), .RomData(RomData), .Busy(Busy)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK)
    if (ROMEnable) RomData <= {rom[(int'(RomAddress) + 1) % 16], rom[int'(RomAddress)]};
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask
  task automatic do_reset();
    #2 RST = 1;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_en", ROMEnable, 0);
    check("rst_raddr", RomAddress, 0);
    check("rst_ack", {Ack1, Ack0}, 0);
    check("rst_err", {Err1, Err0}, 0);
    check("rst_data", {Data1, Data0}, 0);
    #2 RST = 0;
    ph = 0;
    last = 1;
  endtask
  task automatic step(input logic r0, input int a0, input logic r1, input int a1);
    logic ack;
    Req0 = r0;
    Req1 = r1;
    Addr0 = 4'(a0);
    Addr1 = 4'(a1);
    @(posedge CLK);
    if (ph == 0) begin
      if (r0 || r1) begin
        w = (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
        last = w;
        wa = w ? a1 : a0;
        ok = wa >= 0 && wa + 1 <= 15;
        len = ok ? 3 : 1;
        exp_data = ok ? {rom[wa + 1], rom[wa]} : 16'h0;
        ph = 1;
      end
    end else ph = ph == len ? 0 : ph + 1;
    #1;
    ack = ph != 0 && ph == len;
    check("busy", Busy, ph != 0);
    check("en", ROMEnable, ph == 1 && ok);
    if (ph == 1 && ok) check("raddr", RomAddress, wa);
    check("ack0", Ack0, ack && w == 0);
    check("ack1", Ack1, ack && w == 1);
    check("err0", Err0, ack && !ok && w == 0);
    check("err1", Err1, ack && !ok && w == 1);
    check("data0", Data0, ack && w == 0 ? exp_data : 16'h0);
    check("data1", Data1, ack && w == 1 ? exp_data : 16'h0);
  endtask
  initial begin
    int n0, n1;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    rom[4] = 8'h11;
    rom[5] = 8'h22;
    #4 do_reset();
    step(1, 4, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 4, 0, 0);
    step(0, 0, 1, 15);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 15);
    do_reset();
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 2, 1, 6);
      n0 += int'(Ack0);
      n1 += int'(Ack1);
    end
    check("tie_acks0", n0, 2);
    check("tie_acks1", n1, 2);
    step(0, 2, 0, 6);
    step(1, 7, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 3, 0, 0);
    step(0, 3, 0, 0);
    do_reset();
    step(0, 3, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 2, 1, 9);
    for (int i = 0; i < 600; i++) begin
      if (i % 97 == 50) do_reset();
      step($urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom_range(0, 2) != 0, $urandom_range(0, 15));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
